// File: rtl/redundant_stream_vote.sv
// Votes NUM_IN redundant valid/ready lanes into one stream through a DEPTH-entry
// fall-through FIFO, keeping sticky per-lane fault flags and a saturating error count.
module redundant_stream_vote #(
    parameter type T        = logic,
    parameter int  NUM_IN   = 3,
    parameter bit  MAJORITY = 1'b1,
    parameter int  DEPTH    = 2,
    parameter int  CNT_W    = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         repeat_i,
    input  logic                         clear_i,
    input  logic [NUM_IN-1:0]            valid_i,
    output logic [NUM_IN-1:0]            ready_o,
    input  logic [NUM_IN*$bits(T)-1:0]   data_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output T                             data_o,
    output logic                         error_o,
    output logic [NUM_IN-1:0]            fault_o,
    output logic [CNT_W-1:0]             err_cnt_o,
    output logic [$clog2(DEPTH+1)-1:0]   usage_o
);

    localparam int W      = $bits(T);
    localparam int LCNT_W = $clog2(NUM_IN + 1);
    localparam int IDX_W  = $clog2(NUM_IN);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int USE_W  = $clog2(DEPTH + 1);
    localparam logic [LCNT_W-1:0] HALF = LCNT_W'(NUM_IN / 2);

    generate
        if (NUM_IN < 2) begin : g_bad_num_in
            $error("redundant_stream_vote: NUM_IN must be at least 2");
        end
        if (MAJORITY && NUM_IN == 2) begin : g_bad_majority
            $error("redundant_stream_vote: MAJORITY=1 needs NUM_IN of at least 3");
        end
        if (DEPTH < 1) begin : g_bad_depth
            $error("redundant_stream_vote: DEPTH must be at least 1");
        end
    endgenerate

    T                  lane_data [NUM_IN];
    logic [LCNT_W-1:0] agree_cnt [NUM_IN];
    logic              all_equal;
    logic              unanimous;
    logic              maj_found;
    logic [IDX_W-1:0]  maj_idx;
    logic              vote_ok;
    T                  candidate;
    logic [NUM_IN-1:0] dissent;
    logic              accept;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    T                  mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [USE_W-1:0]  usage;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            lane_data[i] = T'(data_i[i*W +: W]);
        end
    end

    // Each lane counts how many valid lanes (itself included) carry its payload.
    always_comb begin
        for (int k = 0; k < NUM_IN; k++) begin
            agree_cnt[k] = '0;
            for (int i = 0; i < NUM_IN; i++) begin
                if (valid_i[i] && valid_i[k] && lane_data[i] == lane_data[k]) begin
                    agree_cnt[k] = agree_cnt[k] + LCNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        maj_found = 1'b0;
        maj_idx   = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (agree_cnt[k] > HALF) begin
                maj_found = 1'b1;
                maj_idx   = IDX_W'(k);
            end
        end
    end

    always_comb begin
        all_equal = 1'b1;
        for (int i = 1; i < NUM_IN; i++) begin
            if (lane_data[i] != lane_data[0]) begin
                all_equal = 1'b0;
            end
        end
    end

    assign unanimous = (&valid_i) && all_equal;
    assign error_o   = (|valid_i) && !unanimous;

    always_comb begin
        vote_ok   = MAJORITY ? maj_found : unanimous;
        candidate = MAJORITY ? lane_data[maj_idx] : lane_data[0];
        for (int i = 0; i < NUM_IN; i++) begin
            dissent[i] = !(valid_i[i] && lane_data[i] == candidate);
        end
    end

    // Full blocks acceptance even when the head pops this cycle, so ready_o never depends on ready_i when full.
    assign full    = (usage == USE_W'(DEPTH));
    assign empty   = (usage == '0);
    assign accept  = vote_ok && !repeat_i && !full;
    assign ready_o = {NUM_IN{accept}};
    assign valid_o = !empty || accept;
    assign data_o  = empty ? candidate : mem[rd_ptr];
    assign pop     = !empty && ready_i;
    assign push    = accept && !(empty && ready_i);
    assign usage_o = usage;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= candidate;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            usage  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                usage <= usage + USE_W'(1);
            end else if (pop && !push) begin
                usage <= usage - USE_W'(1);
            end
        end
    end

    // Clear outranks a same-cycle fault set or count increment.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            fault_o   <= '0;
            err_cnt_o <= '0;
        end else begin
            if (accept) begin
                fault_o <= fault_o | dissent;
            end
            if (error_o && err_cnt_o != '1) begin
                err_cnt_o <= err_cnt_o + CNT_W'(1);
            end
        end
    end

    a_usage_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        usage <= USE_W'(DEPTH));

    a_output_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_o && !ready_i) |=> (valid_o && data_o == $past(data_o)));

endmodule
